// File: rtl/switch_button_debounce_interface.sv
// Front-panel input conditioning: two-flop synchronizers, per-input debouncers,
// and one request/acknowledge channel per push button (write, read).
module switch_button_debounce_interface #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset_n,
    input  logic switch0_raw,
    input  logic switch1_raw,
    input  logic btn_write_raw,
    input  logic btn_read_raw,
    input  logic write_ack,
    input  logic read_ack,
    output logic write_sel,
    output logic read_sel,
    output logic write_req,
    output logic write_block,
    output logic read_req,
    output logic read_block,
    output logic dropped_press
);

    localparam int N_IN = 4;
    localparam int N_CH = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // Bit order: 0 = switch0, 1 = switch1, 2 = write button, 3 = read button.
    // Channel gi of the request logic pairs button gi+2 with switch gi.
    logic [N_IN-1:0] raw_in;
    logic [N_IN-1:0] sync1_q;
    logic [N_IN-1:0] sync2_q;
    logic [N_IN-1:0] stable;

    logic [N_CH-1:0] btn_prev_q;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] ack_in;
    logic [N_CH-1:0] req;
    logic [N_CH-1:0] block;
    logic [N_CH-1:0] dropped;

    assign raw_in = {btn_read_raw, btn_write_raw, switch1_raw, switch0_raw};
    assign ack_in = {read_ack, write_ack};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;

    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             stable_q;
            logic             stable_d;

            // Any sample that agrees with the accepted level restarts the count.
            always_comb begin
                cnt_d    = '0;
                stable_d = stable_q;
                if (sync2_q[gi] != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign stable[gi] = stable_q;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev_q <= '0;
        end else begin
            btn_prev_q <= stable[3:2];
        end
    end

    assign press = stable[3:2] & ~btn_prev_q;

    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [0:0] state_q;
            logic [0:0] state_d;
            logic       block_q;
            logic       block_d;
            logic       drop_q;
            logic       drop_d;

            // A press while busy is discarded, never queued, even alongside an ack.
            always_comb begin
                state_d = state_q;
                block_d = block_q;
                drop_d  = drop_q;
                case (state_q)
                    ST_IDLE: begin
                        if (press[gi]) begin
                            state_d = ST_PENDING;
                            block_d = stable[gi];
                        end
                    end
                    ST_PENDING: begin
                        if (press[gi]) begin
                            drop_d = 1'b1;
                        end
                        if (ack_in[gi]) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    state_q <= ST_IDLE;
                    block_q <= 1'b0;
                    drop_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    block_q <= block_d;
                    drop_q  <= drop_d;
                end
            end

            assign req[gi]     = (state_q == ST_PENDING);
            assign block[gi]   = block_q;
            assign dropped[gi] = drop_q;
        end
    endgenerate

    assign write_sel     = stable[0];
    assign read_sel      = stable[1];
    assign write_req     = req[0];
    assign write_block   = block[0];
    assign read_req      = req[1];
    assign read_block    = block[1];
    assign dropped_press = |dropped;

endmodule

// File: tb/tb_switch_button_debounce_interface.sv
// Bench for switch_button_debounce_interface: vector table, hand sequences for
// latency/bounce/reset corners, and a randomized run against a windowed model.
module tb_switch_button_debounce_interface;

    localparam int D    = 4;
    localparam int HMAX = 8192;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic switch0_raw = 1'b0;
    logic switch1_raw = 1'b0;
    logic btn_write_raw = 1'b0;
    logic btn_read_raw = 1'b0;
    logic write_ack = 1'b0;
    logic read_ack = 1'b0;
    logic write_sel, read_sel, write_req, write_block, read_req, read_block, dropped_press;

    switch_button_debounce_interface #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .switch0_raw  (switch0_raw),
        .switch1_raw  (switch1_raw),
        .btn_write_raw(btn_write_raw),
        .btn_read_raw (btn_read_raw),
        .write_ack    (write_ack),
        .read_ack     (read_ack),
        .write_sel    (write_sel),
        .read_sel     (read_sel),
        .write_req    (write_req),
        .write_block  (write_block),
        .read_req     (read_req),
        .read_block   (read_block),
        .dropped_press(dropped_press)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: raw samples per clock edge since the last reset, the
    // accepted level per edge, and transaction-level channel state.
    bit raw_h [4][HMAX];
    bit st_h  [4][HMAX];
    int mk;
    bit m_pend [2];
    bit m_blk  [2];
    bit m_drop;

    typedef struct {
        bit sw0, sw1, bw, br, wa, ra;
        int n;
        bit ws, rs, wr, wb, rr, rb, dp;
    } vec_t;

    vec_t tbl [14];

    function automatic bit raw_at(int i, int k);
        if (k < 0) return 1'b0;
        return raw_h[i][k];
    endfunction

    function automatic bit st_at(int i, int k);
        if (k < 0) return 1'b0;
        return st_h[i][k];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0b want=%0b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mk     = 0;
        m_pend = '{1'b0, 1'b0};
        m_blk  = '{1'b0, 1'b0};
        m_drop = 1'b0;
    endtask

    // A level is accepted once the synchronized samples of the last D edges
    // (raw sampled two edges earlier) all disagree with the current level.
    task automatic model_edge();
        bit cur [4];
        bit prev, all_opp, press, ack;
        cur = '{switch0_raw, switch1_raw, btn_write_raw, btn_read_raw};
        for (int i = 0; i < 4; i++) raw_h[i][mk] = cur[i];
        for (int i = 0; i < 4; i++) begin
            prev    = st_at(i, mk - 1);
            all_opp = 1'b1;
            for (int j = 0; j < D; j++) begin
                if (raw_at(i, mk - 2 - j) == prev) all_opp = 1'b0;
            end
            st_h[i][mk] = all_opp ? ~prev : prev;
        end
        for (int c = 0; c < 2; c++) begin
            press = st_at(2 + c, mk - 1) && !st_at(2 + c, mk - 2);
            ack   = (c == 0) ? write_ack : read_ack;
            if (m_pend[c]) begin
                if (press) m_drop = 1'b1;
                if (ack) m_pend[c] = 1'b0;
            end else if (press) begin
                m_pend[c] = 1'b1;
                m_blk[c]  = st_at(c, mk - 1);
            end
        end
        mk++;
    endtask

    task automatic compare_model();
        check("model_write_sel", write_sel, st_at(0, mk - 1));
        check("model_read_sel", read_sel, st_at(1, mk - 1));
        check("model_write_req", write_req, m_pend[0]);
        check("model_write_block", write_block, m_blk[0]);
        check("model_read_req", read_req, m_pend[1]);
        check("model_read_block", read_block, m_blk[1]);
        check("model_dropped", dropped_press, m_drop);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_write_sel"}, write_sel, 1'b0);
        check({tag, "_read_sel"}, read_sel, 1'b0);
        check({tag, "_write_req"}, write_req, 1'b0);
        check({tag, "_write_block"}, write_block, 1'b0);
        check({tag, "_read_req"}, read_req, 1'b0);
        check({tag, "_read_block"}, read_block, 1'b0);
        check({tag, "_dropped"}, dropped_press, 1'b0);
    endtask

    // Asserts reset mid-cycle, checks outputs clear without a clock edge,
    // then releases shortly after an edge.
    task automatic reset_pulse(input string tag);
        #3;
        reset_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        $display("reset %s: outputs cleared asynchronously", tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   rises;
        logic prev_req;
        bit   bseq [4];

        //          sw0 sw1 bw br wa ra  n   ws rs wr wb rr rb dp
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 1, 1, 0, 0, 10, 1, 1, 1, 1, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 10, 0, 0, 1, 1, 1, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 1, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0,  2, 0, 0, 1, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 1, 0, 0, 0, 10, 0, 0, 1, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 10, 0, 0, 1, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 10, 0, 0, 1, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 1, 1};
        tbl[13] = '{0, 0, 0, 0, 1, 1,  3, 0, 0, 0, 0, 0, 1, 1};

        model_reset();
        #1;
        check_all_zero("in_reset");
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check_all_zero("after_reset");

        for (int v = 0; v < 14; v++) begin
            switch0_raw   = tbl[v].sw0;
            switch1_raw   = tbl[v].sw1;
            btn_write_raw = tbl[v].bw;
            btn_read_raw  = tbl[v].br;
            write_ack     = tbl[v].wa;
            read_ack      = tbl[v].ra;
            repeat (tbl[v].n) step();
            check($sformatf("vec%0d_write_sel", v), write_sel, tbl[v].ws);
            check($sformatf("vec%0d_read_sel", v), read_sel, tbl[v].rs);
            check($sformatf("vec%0d_write_req", v), write_req, tbl[v].wr);
            check($sformatf("vec%0d_write_block", v), write_block, tbl[v].wb);
            check($sformatf("vec%0d_read_req", v), read_req, tbl[v].rr);
            check($sformatf("vec%0d_read_block", v), read_block, tbl[v].rb);
            check($sformatf("vec%0d_dropped", v), dropped_press, tbl[v].dp);
            $display("vec %0d: in=%0b%0b%0b%0b%0b%0b n=%0d out=%0b%0b%0b%0b%0b%0b%0b",
                     v, tbl[v].sw0, tbl[v].sw1, tbl[v].bw, tbl[v].br, tbl[v].wa, tbl[v].ra,
                     tbl[v].n, write_sel, read_sel, write_req, write_block, read_req,
                     read_block, dropped_press);
        end

        write_ack = 1'b0;
        read_ack  = 1'b0;
        reset_pulse("clear_dropped");

        // Clean switch edge: accepted exactly D+2 edges later.
        repeat (4) step();
        switch0_raw = 1'b1;
        repeat (D + 1) step();
        check("latency_before", write_sel, 1'b0);
        step();
        check("latency_at", write_sel, 1'b1);
        $display("latency: write_sel rose %0d edges after switch0 edge", D + 2);

        // Pulse one cycle shorter than the debounce window is rejected.
        switch0_raw = 1'b0;
        repeat (10) step();
        switch0_raw = 1'b1;
        repeat (D - 1) step();
        switch0_raw = 1'b0;
        repeat (10) step();
        check("short_pulse", write_sel, 1'b0);
        $display("short pulse: write_sel=%0b", write_sel);

        // Bouncy write button with switch0 settled high.
        switch0_raw = 1'b1;
        repeat (10) step();
        rises    = 0;
        prev_req = write_req;
        bseq     = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int b = 0; b < 4; b++) begin
            btn_write_raw = bseq[b];
            step();
            if (write_req && !prev_req) rises++;
            prev_req = write_req;
        end
        btn_write_raw = 1'b1;
        for (int b = 0; b < 20; b++) begin
            step();
            if (write_req && !prev_req) rises++;
            prev_req = write_req;
        end
        check_int("bounce_rises", rises, 1);
        check("bounce_block", write_block, 1'b1);
        switch0_raw = 1'b0;
        repeat (10) step();
        check("frozen_block", write_block, 1'b1);
        check("frozen_sel", write_sel, 1'b0);
        write_ack = 1'b1;
        step();
        write_ack = 1'b0;
        check("ack_clears_req", write_req, 1'b0);
        $display("bounce: rises=%0d block=%0b req_after_ack=%0b", rises, write_block, write_req);

        // Reset in the middle of a debounce count.
        btn_write_raw = 1'b0;
        repeat (10) step();
        switch1_raw = 1'b1;
        repeat (3) step();
        reset_pulse("mid_debounce");

        // Reset while a write is pending, button still held.
        btn_write_raw = 1'b1;
        repeat (10) step();
        check("pending_before_reset", write_req, 1'b1);
        reset_pulse("while_pending");
        repeat (D + 2) step();
        check("held_btn_not_yet", write_req, 1'b0);
        step();
        check("held_btn_req", write_req, 1'b1);
        $display("post-reset: held button raised write_req after %0d edges", D + 3);

        // Randomized activity against the model.
        for (int r = 0; r < 3000; r++) begin
            if ($urandom_range(0, 7) == 0) switch0_raw = ~switch0_raw;
            if ($urandom_range(0, 7) == 0) switch1_raw = ~switch1_raw;
            if ($urandom_range(0, 5) == 0) btn_write_raw = ~btn_write_raw;
            if ($urandom_range(0, 5) == 0) btn_read_raw = ~btn_read_raw;
            write_ack = ($urandom_range(0, 5) == 0);
            read_ack  = ($urandom_range(0, 5) == 0);
            step();
        end
        $display("random: 3000 cycles, dropped=%0b", dropped_press);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
